// File: rtl/result_stream_reader_pkg.sv
// Shared constants and FSM encoding for the result BRAM to AXI4-Stream reader.
package result_stream_reader_pkg;

    localparam int unsigned BRAM_DEPTH_DEF          = 10;
    localparam int unsigned RES_BRAM_DATA_WIDTH_DEF = 64;
    localparam int unsigned BUF_DEPTH               = 3;
    localparam int unsigned BUF_CNT_W               = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/result_stream_skid_fifo.sv
// Small register FIFO that absorbs BRAM read latency against stream backpressure.
module result_stream_skid_fifo
    import result_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = RES_BRAM_DATA_WIDTH_DEF,
    parameter int unsigned DEPTH = BUF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [WIDTH-1:0]                 din,
    input  logic                             pop,
    output logic [WIDTH-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // a full buffer still accepts a push when the head leaves in the same cycle
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_stream_reader.sv
// Streams one frame of result BRAM words out as an AXI4-Stream packet per start pulse.
module result_stream_reader
    import result_stream_reader_pkg::*;
#(
    parameter int unsigned BRAM_DEPTH             = BRAM_DEPTH_DEF,
    parameter int unsigned RES_BRAM_DATA_WIDTH    = RES_BRAM_DATA_WIDTH_DEF,
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = RES_BRAM_DATA_WIDTH_DEF
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic                                  start,
    input  logic [BRAM_DEPTH:0]                   frame_len,
    output logic [BRAM_DEPTH-1:0]                 res_bram_addr_read,
    output logic                                  res_bram_r_enable,
    input  logic [RES_BRAM_DATA_WIDTH-1:0]        res_bram_datain,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tkeep,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tlast,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  start_err
);

    localparam int unsigned CNT_W = BRAM_DEPTH + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic                 inflight_q;
    logic                 done_d;
    logic                 err_d;
    logic                 issue;
    logic                 pace_ok;
    logic                 hs;
    logic [BUF_CNT_W-1:0] buf_count;
    logic                 buf_full;
    logic                 buf_empty;
    logic [RES_BRAM_DATA_WIDTH-1:0] buf_dout;

    result_stream_skid_fifo #(
        .WIDTH (RES_BRAM_DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (m00_axis_aclk),
        .rst_n (m00_axis_aresetn),
        .push  (inflight_q),
        .din   (res_bram_datain),
        .pop   (hs),
        .dout  (buf_dout),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // read pacing looks only at registered occupancy, never at tready
    assign pace_ok = !buf_full &&
                     ((3'(buf_count) + 3'(inflight_q)) <= 3'(BUF_DEPTH - 1));

    assign m00_axis_tvalid    = !buf_empty;
    assign m00_axis_tdata     = C_M00_AXIS_TDATA_WIDTH'(buf_dout);
    assign m00_axis_tkeep     = '1;
    assign m00_axis_tlast     = !buf_empty && (beat_cnt_q == len_q - CNT_W'(1));
    assign hs                 = m00_axis_tvalid && m00_axis_tready;
    assign res_bram_addr_read = rd_cnt_q[BRAM_DEPTH-1:0];
    assign res_bram_r_enable  = issue;
    assign busy               = (state_q != IDLE);

    // next-state, counters and read issue
    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        err_d      = start_err;
        done_d     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len != '0) begin
                        state_d    = RUN;
                        len_d      = frame_len;
                        rd_cnt_d   = '0;
                        beat_cnt_d = '0;
                        err_d      = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (start) err_d = 1'b1;
                if (hs) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (pace_ok) begin
                    issue    = 1'b1;
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == len_q - CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (start) err_d = 1'b1;
                if (hs) beat_cnt_d = beat_cnt_q + CNT_W'(1);
                if (hs && m00_axis_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q    <= IDLE;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            inflight_q <= issue;
            done       <= done_d;
            start_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader with a one-cycle-latency BRAM model.
module tb_result_stream_reader;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [10:0] frame_len = '0;
    logic [9:0]  addr;
    logic        ren;
    logic [63:0] rdata = '0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        busy;
    logic        done;
    logic        start_err;

    logic [63:0] bram [1024];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ren) rdata <= bram[addr];
    end

    result_stream_reader dut (
        .m00_axis_aclk      (clk),
        .m00_axis_aresetn   (aresetn),
        .start              (start),
        .frame_len          (frame_len),
        .res_bram_addr_read (addr),
        .res_bram_r_enable  (ren),
        .res_bram_datain    (rdata),
        .m00_axis_tdata     (tdata),
        .m00_axis_tkeep     (tkeep),
        .m00_axis_tvalid    (tvalid),
        .m00_axis_tready    (tready),
        .m00_axis_tlast     (tlast),
        .busy               (busy),
        .done               (done),
        .start_err          (start_err)
    );

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (addr !== 10'd0 || ren !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 ||
            tdata !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || start_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got addr=%0d ren=%b tvalid=%b tlast=%b tdata=%h busy=%b done=%b err=%b want all zero",
                     addr, ren, tvalid, tlast, tdata, busy, done, start_err);
        end
        checks++;
        if (tkeep !== 8'hff) begin
            errors++;
            $display("FAIL reset_tkeep got %h want ff", tkeep);
        end
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int b = 0;
        @(negedge clk); start = 1'b1; frame_len = 11'd8; tready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk); start = 1'b0;
            checks++;
            if (ren !== (t <= 8) || (ren && addr !== 10'(t - 1))) begin
                errors++;
                $display("FAIL basic_read t=%0d got ren=%b addr=%0d want ren=%b addr=%0d", t, ren, addr, t <= 8, t - 1);
            end
            checks++;
            if (tvalid !== (t >= 3 && t <= 10)) begin
                errors++;
                $display("FAIL basic_valid t=%0d got %b want %b", t, tvalid, (t >= 3 && t <= 10));
            end
            if (tvalid) begin
                checks++;
                if (tdata !== 64'h100 + 64'(b) || tlast !== (b == 7)) begin
                    errors++;
                    $display("FAIL basic_beat b=%0d got data=%h last=%b want data=%h last=%b",
                             b, tdata, tlast, 64'h100 + 64'(b), b == 7);
                end
                b++;
            end
            checks++;
            if (done !== (t == 11) || busy !== (t <= 10)) begin
                errors++;
                $display("FAIL basic_status t=%0d got done=%b busy=%b want done=%b busy=%b", t, done, busy, t == 11, t <= 10);
            end
        end
    endtask

    task automatic test_stall();
        int b = 0, ra = 0, bufm = 0, inf = 0, cyc = 0;
        bit seen_done = 0;
        logic pv = 0, pr = 0, pl = 0, h;
        logic [63:0] pd = '0;
        @(negedge clk); start = 1'b1; frame_len = 11'd16; tready = 1'b1;
        while (!seen_done && cyc < 200) begin
            @(negedge clk); start = 1'b0; tready = cyc[0]; cyc++;
            if (pv && !pr) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, tvalid, tdata, tlast, pd, pl);
                end
            end
            if (tvalid) begin
                checks++;
                if (tdata !== 64'h100 + 64'(b) || tlast !== (b == 15)) begin
                    errors++;
                    $display("FAIL stall_order b=%0d got d=%h l=%b want d=%h l=%b", b, tdata, tlast, 64'h100 + 64'(b), b == 15);
                end
            end
            if (ren) begin
                checks++;
                if (bufm + inf > 2 || addr !== 10'(ra)) begin
                    errors++;
                    $display("FAIL stall_pace cyc=%0d got occ=%0d addr=%0d want occ<=2 addr=%0d", cyc, bufm + inf, addr, ra);
                end
                ra++;
            end
            checks++;
            if (tvalid !== (bufm > 0)) begin
                errors++;
                $display("FAIL stall_valid cyc=%0d got %b want %b", cyc, tvalid, bufm > 0);
            end
            h = tvalid && tready;
            if (h) b++;
            bufm = bufm + inf - int'(h);
            inf = int'(ren);
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            if (done) seen_done = 1;
        end
        checks++;
        if (!seen_done || b != 16 || ra != 16) begin
            errors++;
            $display("FAIL stall_totals got done=%b beats=%0d reads=%0d want 1 16 16", seen_done, b, ra);
        end
        tready = 1'b1;
    endtask

    task automatic test_full_frame();
        int b = 0, ra = 0, cyc = 0, max_addr = 0, late_reads = 0;
        bit seen_done = 0;
        @(negedge clk); start = 1'b1; frame_len = 11'd1024; tready = 1'b1;
        while (!seen_done && cyc < 6000) begin
            @(negedge clk); start = 1'b0; tready = 1'($urandom_range(0, 1)); cyc++;
            if (ren) begin
                checks++;
                if (addr !== 10'(ra) || ra >= 1024) begin
                    errors++;
                    $display("FAIL full_addr got %0d want %0d (reads so far %0d)", addr, 10'(ra), ra);
                end
                if (int'(addr) > max_addr) max_addr = int'(addr);
                ra++;
            end
            if (tvalid && tready) begin
                checks++;
                if (tdata !== 64'h100 + 64'(b) || tlast !== (b == 1023)) begin
                    errors++;
                    $display("FAIL full_beat b=%0d got d=%h l=%b want d=%h l=%b", b, tdata, tlast, 64'h100 + 64'(b), b == 1023);
                end
                b++;
            end
            if (done) seen_done = 1;
        end
        tready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ren || tvalid) late_reads++;
        end
        checks++;
        if (!seen_done || b != 1024 || ra != 1024 || max_addr != 1023 || late_reads != 0) begin
            errors++;
            $display("FAIL full_totals got done=%b beats=%0d reads=%0d max=%0d late=%0d want 1 1024 1024 1023 0",
                     seen_done, b, ra, max_addr, late_reads);
        end
    endtask

    task automatic test_start_err();
        int b = 0;
        @(negedge clk); start = 1'b1; frame_len = 11'd8; tready = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            start = (t == 2); frame_len = (t == 2) ? 11'd3 : 11'd8;
            if (t == 3) begin
                checks++;
                if (start_err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_busy_start got %b want 1", start_err);
                end
            end
            if (tvalid) begin
                checks++;
                if (tdata !== 64'h100 + 64'(b) || tlast !== (b == 7)) begin
                    errors++;
                    $display("FAIL err_frame b=%0d got d=%h l=%b want d=%h l=%b", b, tdata, tlast, 64'h100 + 64'(b), b == 7);
                end
                b++;
            end
            if (t == 11) begin
                checks++;
                if (done !== 1'b1 || b != 8 || start_err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_frame_end got done=%b beats=%0d err=%b want 1 8 1", done, b, start_err);
                end
            end
        end
        start = 1'b0;
        @(negedge clk); start = 1'b1; frame_len = 11'd2;
        @(negedge clk); start = 1'b0;
        checks++;
        if (start_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b busy=%b want 0 1", start_err, busy);
        end
        repeat (6) @(negedge clk);
        @(negedge clk); start = 1'b1; frame_len = 11'd0;
        @(negedge clk); start = 1'b0;
        checks++;
        if (start_err !== 1'b1 || busy !== 1'b0 || ren !== 1'b0) begin
            errors++;
            $display("FAIL err_zero_len got err=%b busy=%b ren=%b want 1 0 0", start_err, busy, ren);
        end
        @(negedge clk); start = 1'b1; frame_len = 11'd1;
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk); start = 1'b0;
            if (t == 1) begin
                checks++;
                if (start_err !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL err_len1_start got err=%b busy=%b want 0 1", start_err, busy);
                end
            end
            checks++;
            if (tvalid !== (t == 3) || (tvalid && (tlast !== 1'b1 || tdata !== 64'h100)) || done !== (t == 4)) begin
                errors++;
                $display("FAIL err_len1 t=%0d got v=%b l=%b d=%h done=%b want v=%b l=1 d=100 done=%b",
                         t, tvalid, tlast, tdata, done, t == 3, t == 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b = 0, cyc = 0, extra = 0;
        @(negedge clk); start = 1'b1; frame_len = 11'd10; tready = 1'b1;
        while (!(tvalid && b == 5) && cyc < 40) begin
            @(negedge clk); start = 1'b0; cyc++;
            if (tvalid && b < 5) b++;
            else if (tvalid && b == 5) break;
        end
        checks++;
        if (!(tvalid && b == 5)) begin
            errors++;
            $display("FAIL mid_reach got beats=%0d valid=%b want 5 1", b, tvalid);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (addr !== 10'd0 || ren !== 1'b0 || tvalid !== 1'b0 || tlast !== 1'b0 ||
            tdata !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || start_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got addr=%0d ren=%b v=%b l=%b d=%h busy=%b done=%b err=%b want all zero",
                     addr, ren, tvalid, tlast, tdata, busy, done, start_err);
        end
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (tvalid || ren || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL mid_no_resume got %0d active cycles want 0", extra);
        end
        b = 0;
        @(negedge clk); start = 1'b1; frame_len = 11'd4;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk); start = 1'b0;
            checks++;
            if (ren !== (t <= 4) || (ren && addr !== 10'(t - 1)) || tvalid !== (t >= 3 && t <= 6)) begin
                errors++;
                $display("FAIL mid_refresh t=%0d got ren=%b addr=%0d v=%b want ren=%b addr=%0d v=%b",
                         t, ren, addr, tvalid, t <= 4, t - 1, (t >= 3 && t <= 6));
            end
            if (tvalid) begin
                checks++;
                if (tdata !== 64'h100 + 64'(b) || tlast !== (b == 3)) begin
                    errors++;
                    $display("FAIL mid_beat b=%0d got d=%h l=%b want d=%h l=%b", b, tdata, tlast, 64'h100 + 64'(b), b == 3);
                end
                b++;
            end
            if (t == 7) begin
                checks++;
                if (done !== 1'b1 || b != 4) begin
                    errors++;
                    $display("FAIL mid_done got done=%b beats=%0d want 1 4", done, b);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = 64'h100 + 64'(i);
        test_reset();
        test_basic();
        test_stall();
        test_full_frame();
        test_start_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
